gf22_pad_pwr_seq: RTL and testbench



---
 rtl/pad_seq_pkg.sv | 62 ++++++
 rtl/pad_seq_timer.sv | 28 ++
 rtl/gf22_pad_pwr_seq.sv | 171 +++++++++++++++++
 tb/tb_gf22_pad_pwr_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_seq_pkg.sv
// Shared types for the GF22 pad power sequencer: state encoding, attribute bit indices, per-state controls.
// Latency: n/a (types and constant functions only); backpressure: n/a.
package pad_seq_pkg;

  typedef enum logic [2:0] {
    PS_OFF     = 3'd0,
    PS_IO_UP   = 3'd1,
    PS_BIAS_UP = 3'd2,
    PS_PWR_UP  = 3'd3,
    PS_READY   = 3'd4,
    PS_OE_DN   = 3'd5,
    PS_PWR_DN  = 3'd6,
    PS_BIAS_DN = 3'd7
  } pad_seq_state_e;

  localparam int PAD_ATTR_PWROK_IDX   = 0;
  localparam int PAD_ATTR_IOPWROK_IDX = 1;
  localparam int PAD_ATTR_BIAS_IDX    = 2;

  typedef struct packed {
    logic iopwrok;
    logic bias;
    logic pwrok;
    logic oe_en;
  } pad_ctrl_t;

  // Each up state and its mirror down state share one control word, so reversals never glitch.
  function automatic pad_ctrl_t state_ctrl(input pad_seq_state_e s);
    pad_ctrl_t c;
    c = '0;
    case (s)
      PS_IO_UP, PS_BIAS_DN: c.iopwrok = 1'b1;
      PS_BIAS_UP, PS_PWR_DN: begin
        c.iopwrok = 1'b1;
        c.bias    = 1'b1;
      end
      PS_PWR_UP, PS_OE_DN: begin
        c.iopwrok = 1'b1;
        c.bias    = 1'b1;
        c.pwrok   = 1'b1;
      end
      PS_READY: begin
        c.iopwrok = 1'b1;
        c.bias    = 1'b1;
        c.pwrok   = 1'b1;
        c.oe_en   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pad_seq_timer.sv
// Loadable down-counter; done_o is high whenever the count sits at zero.
// Latency: load takes effect at the next edge; backpressure: none.
module pad_seq_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at zero so an idle timer keeps reporting done.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gf22_pad_pwr_seq.sv
// Timed power-up/down sequencer for GF22 pad rings: drives PWROK/IOPWROK/BIAS and gates pad OEs.
// Latency: all outputs registered except pad_oe_o (AND with registered oe_en); backpressure: none.
module gf22_pad_pwr_seq
  import pad_seq_pkg::*;
#(
  parameter int PADATTR    = 16,
  parameter int NUM_PADS   = 8,
  parameter int T_IO_CYC   = 16,
  parameter int T_BIAS_CYC = 8,
  parameter int T_PWR_CYC  = 4,
  parameter int T_OFF_CYC  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [NUM_PADS-1:0] core_oe_i,
  output logic [NUM_PADS-1:0] pad_oe_o,
  output logic [PADATTR-1:0]  pad_attributes_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic [2:0]          state_o
);

  localparam int CNT_W = $clog2(max_of4(T_IO_CYC, T_BIAS_CYC, T_PWR_CYC, T_OFF_CYC) + 1);

  localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(T_IO_CYC - 1);
  localparam logic [CNT_W-1:0] BIAS_LOAD = CNT_W'(T_BIAS_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(T_PWR_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(T_OFF_CYC - 1);

  if (T_IO_CYC < 1 || T_BIAS_CYC < 1 || T_PWR_CYC < 1 || T_OFF_CYC < 1) begin : g_bad_timing
    $error("gf22_pad_pwr_seq: every T_*_CYC parameter must be at least 1");
  end

  if (PADATTR < 3) begin : g_bad_padattr
    $error("gf22_pad_pwr_seq: PADATTR must be at least 3");
  end

  pad_seq_state_e   state_q;
  pad_seq_state_e   state_d;
  pad_ctrl_t        ctrl_q;
  logic             ready_q;
  logic             busy_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;

  pad_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  // Next-state and timer load share one decision; a reversal beats an expiring timer.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      PS_OFF: begin
        if (en_i) begin
          state_d   = PS_IO_UP;
          tmr_load  = 1'b1;
          tmr_value = IO_LOAD;
        end
      end
      PS_IO_UP: begin
        if (!en_i) begin
          state_d   = PS_BIAS_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end else if (tmr_done) begin
          state_d   = PS_BIAS_UP;
          tmr_load  = 1'b1;
          tmr_value = BIAS_LOAD;
        end
      end
      PS_BIAS_UP: begin
        if (!en_i) begin
          state_d   = PS_PWR_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end else if (tmr_done) begin
          state_d   = PS_PWR_UP;
          tmr_load  = 1'b1;
          tmr_value = PWR_LOAD;
        end
      end
      PS_PWR_UP: begin
        if (!en_i) begin
          state_d   = PS_OE_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end else if (tmr_done) begin
          state_d = PS_READY;
        end
      end
      PS_READY: begin
        if (!en_i) begin
          state_d   = PS_OE_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end
      end
      PS_OE_DN: begin
        if (en_i) begin
          state_d   = PS_PWR_UP;
          tmr_load  = 1'b1;
          tmr_value = PWR_LOAD;
        end else if (tmr_done) begin
          state_d   = PS_PWR_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end
      end
      PS_PWR_DN: begin
        if (en_i) begin
          state_d   = PS_BIAS_UP;
          tmr_load  = 1'b1;
          tmr_value = BIAS_LOAD;
        end else if (tmr_done) begin
          state_d   = PS_BIAS_DN;
          tmr_load  = 1'b1;
          tmr_value = OFF_LOAD;
        end
      end
      PS_BIAS_DN: begin
        if (en_i) begin
          state_d   = PS_IO_UP;
          tmr_load  = 1'b1;
          tmr_value = IO_LOAD;
        end else if (tmr_done) begin
          state_d = PS_OFF;
        end
      end
      default: state_d = PS_OFF;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= PS_OFF;
      ctrl_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      ready_q <= (state_d == PS_READY);
      busy_q  <= (state_d != PS_OFF) && (state_d != PS_READY);
    end
  end

  always_comb begin
    pad_attributes_o                       = '0;
    pad_attributes_o[PAD_ATTR_PWROK_IDX]   = ctrl_q.pwrok;
    pad_attributes_o[PAD_ATTR_IOPWROK_IDX] = ctrl_q.iopwrok;
    pad_attributes_o[PAD_ATTR_BIAS_IDX]    = ctrl_q.bias;
  end

  assign pad_oe_o = core_oe_i & {NUM_PADS{ctrl_q.oe_en}};
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_gf22_pad_pwr_seq.sv
// Bench for gf22_pad_pwr_seq: default timing plus a fast-timing instance, checked against a level-based model.
module tb_gf22_pad_pwr_seq;
  import pad_seq_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        en_i;
  logic [7:0]  core_oe_i;

  logic [7:0]  oe0, oe1;
  logic [15:0] attr0, attr1;
  logic        rdy0, rdy1, bsy0, bsy1;
  logic [2:0]  st0, st1;

  int vectors = 0;
  int miscompares = 0;

  // Model: power level 0..4 (off, io, bias, pwr, ready), ramp direction, cycles left at this level.
  int lvl [2];
  int rem [2];
  bit up_dir [2];
  int tio   [2] = '{16, 1};
  int tbias [2] = '{8, 1};
  int tpwr  [2] = '{4, 1};
  int toff  [2] = '{4, 2};

  gf22_pad_pwr_seq u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .core_oe_i(core_oe_i),
    .pad_oe_o(oe0), .pad_attributes_o(attr0), .ready_o(rdy0), .busy_o(bsy0), .state_o(st0)
  );

  gf22_pad_pwr_seq #(
    .T_IO_CYC(1), .T_BIAS_CYC(1), .T_PWR_CYC(1), .T_OFF_CYC(2)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .core_oe_i(core_oe_i),
    .pad_oe_o(oe1), .pad_attributes_o(attr1), .ready_o(rdy1), .busy_o(bsy1), .state_o(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int t_up(input int i, input int l);
    if (l == 1) return tio[i];
    if (l == 2) return tbias[i];
    return tpwr[i];
  endfunction

  task automatic model_step(input int i, input bit en, input bit rn);
    if (!rn) begin
      lvl[i] = 0; rem[i] = 0; up_dir[i] = 1'b1;
    end else if (lvl[i] == 0) begin
      if (en) begin lvl[i] = 1; up_dir[i] = 1'b1; rem[i] = t_up(i, 1); end
    end else if (lvl[i] == 4) begin
      if (!en) begin lvl[i] = 3; up_dir[i] = 1'b0; rem[i] = toff[i]; end
    end else if (en != up_dir[i]) begin
      up_dir[i] = en;
      rem[i] = en ? t_up(i, lvl[i]) : toff[i];
    end else begin
      rem[i]--;
      if (rem[i] == 0) begin
        if (up_dir[i]) begin
          lvl[i]++;
          if (lvl[i] < 4) rem[i] = t_up(i, lvl[i]);
        end else begin
          lvl[i]--;
          if (lvl[i] > 0) rem[i] = toff[i];
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_state(input int i);
    if (lvl[i] == 0) return PS_OFF;
    if (lvl[i] == 4) return PS_READY;
    if (up_dir[i]) begin
      if (lvl[i] == 1) return PS_IO_UP;
      if (lvl[i] == 2) return PS_BIAS_UP;
      return PS_PWR_UP;
    end
    if (lvl[i] == 1) return PS_BIAS_DN;
    if (lvl[i] == 2) return PS_PWR_DN;
    return PS_OE_DN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int i, input logic [15:0] attr, input logic [7:0] oe,
                           input logic rdy, input logic bsy, input logic [2:0] st);
    logic [15:0] ea;
    ea = '0;
    ea[1] = (lvl[i] >= 1);
    ea[2] = (lvl[i] >= 2);
    ea[0] = (lvl[i] >= 3);
    chk($sformatf("dut%0d attr", i), 32'(attr), 32'(ea));
    chk($sformatf("dut%0d pad_oe", i), 32'(oe), 32'(core_oe_i & {8{lvl[i] == 4}}));
    chk($sformatf("dut%0d ready", i), 32'(rdy), 32'(lvl[i] == 4));
    chk($sformatf("dut%0d busy", i), 32'(bsy), 32'(lvl[i] != 0 && lvl[i] != 4));
    chk($sformatf("dut%0d state", i), 32'(st), 32'(exp_state(i)));
  endtask

  task automatic cycle(input bit en, input bit rn, input logic [7:0] oe);
    en_i = en; rst_ni = rn; core_oe_i = oe;
    @(posedge clk);
    model_step(0, en, rn);
    model_step(1, en, rn);
    #1;
    check_dut(0, attr0, oe0, rdy0, bsy0, st0);
    check_dut(1, attr1, oe1, rdy1, bsy1, st1);
  endtask

  initial begin
    int first0, first1, f_pwr, f_bias, f_io, n;
    rst_ni = 1'b0; en_i = 1'b0; core_oe_i = 8'h00;
    for (int i = 0; i < 2; i++) begin lvl[i] = 0; rem[i] = 0; up_dir[i] = 1'b1; end

    // Reset, then idle with en low.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 8'hA5);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 8'hFF);

    // Full ramp: ready after 28 edges (default) and 3 edges (fast).
    first0 = -1; first1 = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b1, 8'($urandom()));
      if (first0 < 0 && rdy0) first0 = k;
      if (first1 < 0 && rdy1) first1 = k;
    end
    chk("ramp_latency_dut0", 32'(first0), 32'd28);
    chk("ramp_latency_dut1", 32'(first1), 32'd3);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 8'($urandom()));

    // Power-down from READY with all core OEs requested.
    first0 = -1; f_pwr = -1; f_bias = -1; f_io = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, 8'hFF);
      if (k == 0) chk("oe_gate_at_drop", 32'(oe0), 32'h0);
      if (first0 < 0 && !rdy0) first0 = k;
      if (f_pwr < 0 && !attr0[0]) f_pwr = k;
      if (f_bias < 0 && !attr0[2]) f_bias = k;
      if (f_io < 0 && !attr0[1]) f_io = k;
    end
    chk("down_ready_idx", 32'(first0), 32'd0);
    chk("down_pwrok_idx", 32'(f_pwr), 32'd4);
    chk("down_bias_idx", 32'(f_bias), 32'd8);
    chk("down_iopwrok_idx", 32'(f_io), 32'd12);
    chk("down_final_state", 32'(st0), 32'(PS_OFF));

    // Drop en three cycles into BIAS_UP.
    for (int k = 0; k < 19; k++) cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, 8'h3C);
    chk("rev_bias_state", 32'(st0), 32'(PS_PWR_DN));
    chk("rev_bias_attr", 32'(attr0[2:0]), 32'h6);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, 8'h3C);
    chk("rev_bias_not_off_yet", 32'(st0), 32'(PS_BIAS_DN));
    cycle(1'b0, 1'b1, 8'h3C);
    chk("rev_bias_off", 32'(st0), 32'(PS_OFF));

    // Bounce back up from OE_DN.
    for (int k = 0; k < 30; k++) cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'h5A);
    chk("oe_dn_state", 32'(st0), 32'(PS_OE_DN));
    cycle(1'b1, 1'b1, 8'h5A);
    chk("oe_dn_rev_state", 32'(st0), 32'(PS_PWR_UP));
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 1'b1, 8'h5A);
      if (n < 0 && rdy0) n = k;
    end
    chk("oe_dn_rev_ready_lat", 32'(n), 32'd4);

    // Reset in PWR_UP, then a fresh full ramp.
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 26; k++) cycle(1'b1, 1'b1, 8'hF0);
    chk("pre_reset_state", 32'(st0), 32'(PS_PWR_UP));
    cycle(1'b1, 1'b0, 8'hF0);
    chk("mid_reset_state", 32'(st0), 32'(PS_OFF));
    chk("mid_reset_attr", 32'(attr0), 32'h0);
    first0 = -1;
    for (int k = 0; k < 32; k++) begin
      cycle(1'b1, 1'b1, 8'hF0);
      if (first0 < 0 && rdy0) first0 = k;
    end
    chk("re_ramp_latency", 32'(first0), 32'd28);

    // Random en hold lengths, occasional reset, random OEs.
    for (int blk = 0; blk < 150; blk++) begin
      bit e;
      int len;
      e = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++)
        cycle(e, ($urandom_range(0, 299) != 0), 8'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
